// File: rtl/adpcm_code_unpacker.sv
// Decoder-side unpacker: buffers packed code bytes in a 2-entry FIFO and
// hands one 4-bit ADPCM code to the decoder per sample tick.
module adpcm_code_unpacker #(
    parameter int unsigned NIBBLE_ORDER = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             tick,
    input  logic             flush,
    output logic [3:0]       code,
    output logic             code_valid,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt,
    input  logic             clr_cnt
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned COUNT_W = 2;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    logic [BYTE_W-1:0]  mem [DEPTH];
    logic               wptr;
    logic               rptr;
    logic [COUNT_W-1:0] count;
    phase_t             phase;

    logic               wptr_n;
    logic               rptr_n;
    logic [COUNT_W-1:0] count_n;
    phase_t             phase_n;
    logic [CODE_W-1:0]  code_n;
    logic               code_valid_n;
    logic               underrun_n;
    logic [CNT_W-1:0]   underrun_cnt_n;
    logic               in_ready_n;

    logic [BYTE_W-1:0]  head;
    logic [CODE_W-1:0]  first_nib;
    logic [CODE_W-1:0]  second_nib;
    logic               push;
    logic               pop;
    logic               wr_en;

    // Nibble selection for the byte at the head of the FIFO.
    always_comb begin
        head = mem[rptr];
        if (NIBBLE_ORDER == 0) begin
            first_nib  = head[3:0];
            second_nib = head[7:4];
        end else begin
            first_nib  = head[7:4];
            second_nib = head[3:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            count        <= '0;
            phase        <= PH_FIRST;
            code         <= '0;
            code_valid   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            in_ready     <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= in_data;
            end
            wptr         <= wptr_n;
            rptr         <= rptr_n;
            count        <= count_n;
            phase        <= phase_n;
            code         <= code_n;
            code_valid   <= code_valid_n;
            underrun     <= underrun_n;
            underrun_cnt <= underrun_cnt_n;
            in_ready     <= in_ready_n;
        end
    end

    // Next-state: tick service, FIFO bookkeeping, flush and counter clear.
    always_comb begin
        wptr_n         = wptr;
        rptr_n         = rptr;
        count_n        = count;
        phase_n        = phase;
        code_n         = code;
        code_valid_n   = 1'b0;
        underrun_n     = 1'b0;
        underrun_cnt_n = underrun_cnt;
        in_ready_n     = in_ready;
        pop            = 1'b0;
        push           = in_valid && in_ready && !flush;
        wr_en          = push;

        // A tick concurrent with flush is treated as if the buffer were empty.
        if (tick) begin
            code_valid_n = 1'b1;
            if (flush || (count == '0)) begin
                code_n     = '0;
                underrun_n = 1'b1;
                if (underrun_cnt != '1) begin
                    underrun_cnt_n = underrun_cnt + CNT_W'(1);
                end
            end else if (phase == PH_FIRST) begin
                code_n  = first_nib;
                phase_n = PH_SECOND;
            end else begin
                code_n  = second_nib;
                phase_n = PH_FIRST;
                pop     = 1'b1;
            end
        end

        if (clr_cnt) begin
            underrun_cnt_n = '0;
        end

        if (flush) begin
            wptr_n  = 1'b0;
            rptr_n  = 1'b0;
            count_n = '0;
            phase_n = PH_FIRST;
        end else begin
            if (push) begin
                wptr_n = ~wptr;
            end
            if (pop) begin
                rptr_n = ~rptr;
            end
            count_n = count + COUNT_W'(push) - COUNT_W'(pop);
        end

        in_ready_n = (count_n < COUNT_W'(DEPTH)) && !flush;
    end

endmodule

// File: tb/tb_adpcm_code_unpacker.sv
// Bench for adpcm_code_unpacker: two instances (low-nibble-first with a wide
// counter, high-nibble-first with a 2-bit counter) against a queue-based model.
module tb_adpcm_code_unpacker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       tick = 1'b0;
    logic       flush = 1'b0;
    logic       clr_cnt = 1'b0;

    logic        rdy0, rdy1, cv0, cv1, ur0, ur1;
    logic [3:0]  code0, code1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adpcm_code_unpacker #(.NIBBLE_ORDER(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .tick(tick), .flush(flush), .code(code0),
        .code_valid(cv0), .underrun(ur0), .underrun_cnt(cnt0), .clr_cnt(clr_cnt)
    );

    adpcm_code_unpacker #(.NIBBLE_ORDER(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .tick(tick), .flush(flush), .code(code1),
        .code_valid(cv1), .underrun(ur1), .underrun_cnt(cnt1), .clr_cnt(clr_cnt)
    );

    // Reference model: a byte queue plus a "first nibble already used" flag.
    logic [7:0] mq[$];
    bit         m_half;
    logic [3:0] m_code0, m_code1;
    bit         m_cv, m_ur, m_rdy, m_pushed, m_push;
    int         m_cnt0, m_cnt1;
    logic [7:0] m_head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            mq.delete();
            m_half = 0; m_code0 = 4'h0; m_code1 = 4'h0;
            m_cv = 0; m_ur = 0; m_rdy = 0; m_pushed = 0;
            m_cnt0 = 0; m_cnt1 = 0;
            return;
        end
        m_push   = in_valid && m_rdy && !flush;
        m_pushed = m_push;
        m_cv     = tick;
        m_ur     = 0;
        if (tick) begin
            if (flush || mq.size() == 0) begin
                m_code0 = 4'h0; m_code1 = 4'h0; m_ur = 1;
                if (m_cnt0 < 65535) m_cnt0++;
                if (m_cnt1 < 3) m_cnt1++;
            end else begin
                m_head = mq[0];
                if (!m_half) begin
                    m_code0 = m_head[3:0]; m_code1 = m_head[7:4];
                end else begin
                    m_code0 = m_head[7:4]; m_code1 = m_head[3:0];
                    void'(mq.pop_front());
                end
                m_half = !m_half;
            end
        end
        if (clr_cnt) begin
            m_cnt0 = 0; m_cnt1 = 0;
        end
        if (flush) begin
            mq.delete();
            m_half = 0;
        end else if (m_push) begin
            mq.push_back(in_data);
        end
        m_rdy = (mq.size() < 2) && !flush;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        chk("code0", 32'(code0), 32'(m_code0));
        chk("code1", 32'(code1), 32'(m_code1));
        chk("code_valid0", 32'(cv0), 32'(m_cv));
        chk("code_valid1", 32'(cv1), 32'(m_cv));
        chk("underrun0", 32'(ur0), 32'(m_ur));
        chk("underrun1", 32'(ur1), 32'(m_ur));
        chk("in_ready0", 32'(rdy0), 32'(m_rdy));
        chk("in_ready1", 32'(rdy1), 32'(m_rdy));
        chk("underrun_cnt0", 32'(cnt0), m_cnt0);
        chk("underrun_cnt1", 32'(cnt1), m_cnt1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (m_pushed) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("push_timeout", 32'(ok), 32'd1);
    endtask

    logic [3:0] exp0 [4] = '{4'h5, 4'hA, 4'hC, 4'h3};
    logic [3:0] exp1 [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
    logic [3:0] exp_full [4] = '{4'h2, 4'h2, 4'h3, 4'h3};

    initial begin
        // Reset state and release.
        cyc(3);
        chk("rst_in_ready", 32'(rdy0), 32'd0);
        chk("rst_code", 32'(code0), 32'd0);
        reset = 1'b1;
        cyc(1);
        chk("in_ready_after_release", 32'(rdy0), 32'd1);

        // Basic ordering, both nibble orders.
        push_byte(8'hA5);
        push_byte(8'h3C);
        for (int i = 0; i < 4; i++) begin
            cyc(2);
            do_tick();
            chk("seq_code0", 32'(code0), 32'(exp0[i]));
            chk("seq_code1", 32'(code1), 32'(exp1[i]));
            chk("seq_cv", 32'(cv0), 32'd1);
            chk("seq_ur", 32'(ur0), 32'd0);
        end
        chk("seq_in_ready", 32'(rdy0), 32'd1);
        cyc(1);
        chk("cv_drops", 32'(cv0), 32'd0);
        chk("code_holds", 32'(code0), 32'h3);

        // Full buffer back-pressure.
        push_byte(8'h11);
        push_byte(8'h22);
        in_valid = 1'b1;
        in_data  = 8'h33;
        cyc(1);
        chk("full_not_ready", 32'(rdy0), 32'd0);
        do_tick();
        chk("full_tick1_ready", 32'(rdy0), 32'd0);
        chk("full_tick1_code", 32'(code0), 32'h1);
        do_tick();
        chk("full_tick2_ready", 32'(rdy0), 32'd1);
        cyc(1);
        chk("full_accepted", 32'(rdy0), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk("drain_code0", 32'(code0), 32'(exp_full[i]));
        end

        // Underruns and counter saturation/clear.
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            do_tick();
            chk("ur_code", 32'(code0), 32'd0);
            chk("ur_pulse", 32'(ur0), 32'd1);
        end
        chk("ur_cnt0_3", 32'(cnt0), 32'd3);
        chk("ur_cnt1_3", 32'(cnt1), 32'd3);
        do_tick();
        do_tick();
        chk("ur_cnt0_5", 32'(cnt0), 32'd5);
        chk("ur_cnt1_sat", 32'(cnt1), 32'd3);
        clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        chk("clr_cnt0", 32'(cnt0), 32'd0);
        chk("clr_cnt1", 32'(cnt1), 32'd0);

        // Flush discards a half-consumed byte.
        push_byte(8'h76);
        do_tick();
        chk("flush_pre_code", 32'(code0), 32'h6);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("flush_not_ready", 32'(rdy0), 32'd0);
        do_tick();
        chk("flush_code", 32'(code0), 32'd0);
        chk("flush_ur", 32'(ur0), 32'd1);
        push_byte(8'h98);
        do_tick();
        chk("post_flush_lo", 32'(code0), 32'h8);
        do_tick();
        chk("post_flush_hi", 32'(code0), 32'h9);

        // Asynchronous reset mid-stream.
        push_byte(8'hF0);
        do_tick();
        chk("pre_rst_code0", 32'(code0), 32'h0);
        chk("pre_rst_code1", 32'(code1), 32'hF);
        reset = 1'b0;
        #1;
        chk("async_code1", 32'(code1), 32'd0);
        chk("async_cv", 32'(cv0), 32'd0);
        chk("async_ready", 32'(rdy0), 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        do_tick();
        chk("post_rst_ur", 32'(ur0), 32'd1);
        chk("post_rst_code", 32'(code1), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                cyc(1);
                reset = 1'b1;
            end
            if (!in_valid || m_pushed) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
            end
            tick    = ($urandom_range(0, 1) == 1);
            flush   = ($urandom_range(0, 40) == 0);
            clr_cnt = ($urandom_range(0, 60) == 0);
            cyc(1);
        end
        in_valid = 1'b0;
        tick     = 1'b0;
        flush    = 1'b0;
        clr_cnt  = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
